// File: rtl/perceptron_train_ctrl.sv
// Perceptron training sequencer: streams Q6.9 samples from a registered-read memory,
// accumulates the dot product, and applies the perceptron update on each misclassification.
//
// state | meaning
// IDLE  | waiting for start
// FETCH | issue read of word k of the current sample (features, then label)
// WAIT  | last read returns; capture label
// EVAL  | compare prediction with label, update weights on mismatch
// DONE  | one-cycle done pulse
module perceptron_train_ctrl #(
  parameter int N_FEAT    = 2,
  parameter int N_SAMPLES = 100,
  parameter int FRAC      = 9,
  parameter int LR_SHIFT  = 3,
  localparam int SEL_W    = $clog2(N_FEAT + 1),
  localparam int IDX_W    = $clog2(N_SAMPLES + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             mem_ena,
  output logic             wr_rd,
  output logic [10:0]      addr,
  input  logic [15:0]      mem_data,
  output logic             busy,
  output logic             done,
  output logic [10:0]      err_count,
  input  logic [SEL_W-1:0] w_sel,
  output logic [15:0]      w_rd
);

  typedef enum logic [2:0] {IDLE, FETCH, WAIT, EVAL, DONE} state_t;

  localparam int BIAS_STEP = (1 << FRAC) >> LR_SHIFT;

  state_t             state;
  logic [SEL_W-1:0]   k;
  logic [IDX_W-1:0]   sample_idx;
  logic [10:0]        base;
  logic signed [39:0] acc;
  logic               label_neg;
  logic signed [15:0] w      [N_FEAT+1];
  logic signed [15:0] w_next [N_FEAT+1];
  logic signed [15:0] x      [N_FEAT];
  logic signed [15:0] w_cur;
  logic signed [31:0] prod;
  logic               mismatch;

  function automatic logic signed [15:0] upd(input logic signed [15:0] wv,
                                             input logic signed [15:0] dv,
                                             input logic neg);
    logic signed [17:0] s;
    s = neg ? ($signed({{2{wv[15]}}, wv}) - $signed({{2{dv[15]}}, dv}))
            : ($signed({{2{wv[15]}}, wv}) + $signed({{2{dv[15]}}, dv}));
    if (s > 18'sd32767)       return 16'sh7fff;
    else if (s < -18'sd32768) return 16'sh8000;
    else                      return s[15:0];
  endfunction

  // The word arriving in FETCH k>0 is feature k-1, so select its weight for the MAC.
  always_comb begin
    w_cur = '0;
    for (int i = 0; i < N_FEAT; i++)
      if (k == SEL_W'(i + 1)) w_cur = w[i];
    prod = w_cur * $signed(mem_data);
  end

  always_comb begin
    for (int i = 0; i < N_FEAT; i++)
      w_next[i] = upd(w[i], x[i] >>> LR_SHIFT, label_neg);
    w_next[N_FEAT] = upd(w[N_FEAT], 16'(BIAS_STEP), label_neg);
  end

  always_comb begin
    w_rd = '0;
    for (int i = 0; i <= N_FEAT; i++)
      if (w_sel == SEL_W'(i)) w_rd = w[i];
  end

  assign mismatch = acc[39] != label_neg;
  assign wr_rd    = 1'b0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      k          <= '0;
      sample_idx <= '0;
      base       <= '0;
      acc        <= '0;
      label_neg  <= 1'b0;
      mem_ena    <= 1'b0;
      addr       <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err_count  <= '0;
      for (int i = 0; i <= N_FEAT; i++) w[i] <= '0;
      for (int i = 0; i < N_FEAT; i++)  x[i] <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state      <= FETCH;
            k          <= '0;
            sample_idx <= '0;
            base       <= '0;
            addr       <= '0;
            mem_ena    <= 1'b1;
            busy       <= 1'b1;
            err_count  <= '0;
          end
        end
        FETCH: begin
          if (k == '0) begin
            acc <= {{(40 - 16 - FRAC){w[N_FEAT][15]}}, w[N_FEAT], {FRAC{1'b0}}};
          end else begin
            acc <= acc + {{8{prod[31]}}, prod};
            for (int i = 0; i < N_FEAT; i++)
              if (k == SEL_W'(i + 1)) x[i] <= mem_data;
          end
          if (k == SEL_W'(N_FEAT)) begin
            state   <= WAIT;
            mem_ena <= 1'b0;
          end else begin
            k    <= k + 1'b1;
            addr <= base + 11'(k) + 11'd1;
          end
        end
        WAIT: begin
          label_neg <= mem_data[15];
          state     <= EVAL;
        end
        EVAL: begin
          if (mismatch) begin
            for (int i = 0; i <= N_FEAT; i++) w[i] <= w_next[i];
            if (err_count != 11'h7ff) err_count <= err_count + 11'd1;
          end
          if (sample_idx == IDX_W'(N_SAMPLES - 1)) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state      <= FETCH;
            k          <= '0;
            sample_idx <= sample_idx + 1'b1;
            base       <= base + 11'(N_FEAT + 1);
            addr       <= base + 11'(N_FEAT + 1);
            mem_ena    <= 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_perceptron_train_ctrl.sv
// Directed bench: two instances (learning-rate shift 3 and 0), each with 2 samples of 2 features.
`timescale 1ns/1ps
module tb_perceptron_train_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [1:0]  w_sel;
  logic        start_a, start_b;
  logic        mem_ena_a, mem_ena_b, wr_rd_a, wr_rd_b;
  logic [10:0] addr_a, addr_b, err_a, err_b;
  logic [15:0] mem_data_a, mem_data_b, w_rd_a, w_rd_b;
  logic        busy_a, busy_b, done_a, done_b;
  logic [15:0] mem_a [2048];
  logic [15:0] mem_b [2048];

  perceptron_train_ctrl #(.N_FEAT(2), .N_SAMPLES(2), .FRAC(9), .LR_SHIFT(3)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .mem_ena(mem_ena_a), .wr_rd(wr_rd_a),
    .addr(addr_a), .mem_data(mem_data_a), .busy(busy_a), .done(done_a),
    .err_count(err_a), .w_sel(w_sel), .w_rd(w_rd_a));

  perceptron_train_ctrl #(.N_FEAT(2), .N_SAMPLES(2), .FRAC(9), .LR_SHIFT(0)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .mem_ena(mem_ena_b), .wr_rd(wr_rd_b),
    .addr(addr_b), .mem_data(mem_data_b), .busy(busy_b), .done(done_b),
    .err_count(err_b), .w_sel(w_sel), .w_rd(w_rd_b));

  always @(posedge clk) if (mem_ena_a) mem_data_a <= mem_a[addr_a];
  always @(posedge clk) if (mem_ena_b) mem_data_b <= mem_b[addr_b];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    bit             dut;
    logic [5:0][15:0] d;
    int             ew0, ew1, eb, eerr;
  } vec_t;

  function automatic vec_t mk(bit dut, int a, int b, int c, int d, int e, int f,
                              int ew0, int ew1, int eb, int eerr);
    vec_t v;
    v.dut = dut;
    v.d[0] = 16'(a); v.d[1] = 16'(b); v.d[2] = 16'(c);
    v.d[3] = 16'(d); v.d[4] = 16'(e); v.d[5] = 16'(f);
    v.ew0 = ew0; v.ew1 = ew1; v.eb = eb; v.eerr = eerr;
    return v;
  endfunction

  function automatic longint rd_w(bit sel);
    return sel ? longint'($signed(w_rd_b)) : longint'($signed(w_rd_a));
  endfunction

  task automatic run_pass(input bit sel);
    bit seen = 1'b0;
    @(negedge clk);
    if (sel) start_b = 1'b1; else start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0; start_b = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      seen = sel ? done_b : done_a;
    end
    chk("pass_done_seen", longint'(seen), 1);
    @(negedge clk);
  endtask

  // Cycle-by-cycle sequencing on dut_a; optionally pokes start during F1 and in DONE.
  task automatic seq_test(input bit poke);
    int ndone = 0;
    longint e_addr;
    @(negedge clk);
    start_a = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      if (i == 1) start_a = 1'b0;
      e_addr = (i <= 3) ? i - 1 : (i <= 5) ? 2 : (i <= 8) ? i - 3 : 5;
      chk($sformatf("seq%0d_mem_ena_c%0d", poke, i), longint'(mem_ena_a),
          ((i >= 1 && i <= 3) || (i >= 6 && i <= 8)) ? 1 : 0);
      chk($sformatf("seq%0d_addr_c%0d", poke, i), longint'(addr_a), e_addr);
      chk($sformatf("seq%0d_busy_c%0d", poke, i), longint'(busy_a), (i <= 10) ? 1 : 0);
      chk($sformatf("seq%0d_wr_rd_c%0d", poke, i), longint'(wr_rd_a), 0);
      if (done_a) ndone++;
      if (i == 11) chk($sformatf("seq%0d_done_c11", poke), longint'(done_a), 1);
      if (poke && (i == 2 || i == 11)) start_a = 1'b1;
      if (poke && (i == 3 || i == 12)) start_a = 1'b0;
    end
    chk($sformatf("seq%0d_done_pulses", poke), ndone, 1);
  endtask

  vec_t vt[5];

  initial begin
    rst = 1'b1; start_a = 1'b0; start_b = 1'b0; w_sel = '0;
    for (int i = 0; i < 2048; i++) begin mem_a[i] = '0; mem_b[i] = '0; end
    vt[0] = mk(0,   512,  -256, -512,  512,  -256, -512,    -64,    32, -64, 1);
    vt[1] = mk(0,   512,  -256, -512,  512,  -256, -512,    -64,    32, -64, 0);
    vt[2] = mk(0, -1000,   300,    0,    7,    -9,    5,    -64,    30,   0, 1);
    vt[3] = mk(1, 32767,     0,  512,  100, -32768, -512,  -100, 32767, -512, 1);
    vt[4] = mk(1, 32767, 32767, -512,    0,     0,    0, -32768,     0, -512, 2);

    repeat (2) @(negedge clk);
    chk("rst_mem_ena", longint'(mem_ena_a), 0);
    chk("rst_addr", longint'(addr_a), 0);
    chk("rst_busy", longint'(busy_a), 0);
    chk("rst_done", longint'(done_a), 0);
    chk("rst_err", longint'(err_a), 0);
    chk("rst_wr_rd", longint'(wr_rd_a), 0);
    chk("rst_b_busy", longint'(busy_b), 0);
    rst = 1'b0;
    @(negedge clk);

    for (int v = 0; v < 5; v++) begin
      for (int j = 0; j < 6; j++)
        if (vt[v].dut) mem_b[j] = vt[v].d[j]; else mem_a[j] = vt[v].d[j];
      run_pass(vt[v].dut);
      w_sel = 2'd0; #1 chk($sformatf("vec%0d_w0", v), rd_w(vt[v].dut), vt[v].ew0);
      w_sel = 2'd1; #1 chk($sformatf("vec%0d_w1", v), rd_w(vt[v].dut), vt[v].ew1);
      w_sel = 2'd2; #1 chk($sformatf("vec%0d_bias", v), rd_w(vt[v].dut), vt[v].eb);
      chk($sformatf("vec%0d_err", v),
          vt[v].dut ? longint'(err_b) : longint'(err_a), vt[v].eerr);
    end

    seq_test(1'b0);
    seq_test(1'b1);

    // Weights of dut_a are nonzero here; reset mid-pass must clear everything at once.
    @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("midrst_mem_ena", longint'(mem_ena_a), 0);
    chk("midrst_addr", longint'(addr_a), 0);
    chk("midrst_busy", longint'(busy_a), 0);
    chk("midrst_done", longint'(done_a), 0);
    chk("midrst_err", longint'(err_a), 0);
    for (int s = 0; s < 3; s++) begin
      w_sel = 2'(s);
      #0.5 chk($sformatf("midrst_w%0d_a", s), rd_w(1'b0), 0);
      chk($sformatf("midrst_w%0d_b", s), rd_w(1'b1), 0);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
